// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: groups the pipeline sequencer's request/handshake inputs
// and its latch-control and status outputs.
//   master : hazard unit / caches / EX-MEM side (drives requests, sees controls)
//   slave  : pipeline_ctrl (consumes requests, drives controls and status)
// CNT_W must match the CNT_W of the pipeline_ctrl instance connected to it.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   // requests and handshakes
   logic             lw_nop;
   logic             jmp_flush;
   logic             brch_flush;
   logic             ihit;
   logic             exmem_dren;
   logic             exmem_dwen;
   logic             dhit;
   logic             exmem_halt;
   // latch enables and bubble controls
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             memwb_flush;
   // status
   logic             halt;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output lw_nop, jmp_flush, brch_flush, ihit,
             exmem_dren, exmem_dwen, dhit, exmem_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             halt, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  lw_nop, jmp_flush, brch_flush, ihit,
             exmem_dren, exmem_dwen, dhit, exmem_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             halt, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencer for the 5-stage MIPS pipeline. Resolves halt,
// data-memory wait, control flush, load-use stall and I-fetch miss (in that
// priority) into per-stage latch enables and bubble flushes. Also runs a
// data-wait watchdog, a sticky halt flag and saturating stall/flush counters.
// Ports:
//   CLK  : core clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : pipeline_ctrl_if.slave (requests in; enables, flushes, status out)
// Enables/flushes are combinational; halt, mem_timeout and counters are flops.
module pipeline_ctrl #(
   parameter int CNT_W     = 32,
   parameter int DWAIT_MAX = 255
) (
   input logic           CLK,
   input logic           nRST,
   pipeline_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [31:0]      WAIT_LIMIT = 32'(DWAIT_MAX);

   state_e           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [7:0]       wait_inc;
   logic             halt_q, halt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic active, dreq, dwait_take, halt_take, flush_take;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

   // Priority decode: each request only wins if all higher ones are absent.
   always_comb begin
      active     = (state_q != HALTED);
      dreq       = bus.exmem_dren | bus.exmem_dwen;
      dwait_take = active & dreq & ~bus.dhit;
      // a HALT behind an outstanding data access waits for the access first
      halt_take  = active & bus.exmem_halt & ~dwait_take;
      flush_take = active & ~dwait_take & ~halt_take & (bus.jmp_flush | bus.brch_flush);
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; HALTED is left only through reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN, DWAIT: begin
            if (halt_take) begin
               state_d = HALTED;
            end else if (dwait_take) begin
               state_d = DWAIT;
            end else begin
               state_d = RUN;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // FSM outputs: latch enables and bubble flushes, all forced low in reset.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      if (!nRST) begin
         pc_en = 1'b0;
      end else begin
         case (state_q)
            RUN, DWAIT: begin
               if (halt_take) begin
                  // retire the HALT into WB, freeze everything else
                  memwb_en = 1'b1;
               end else if (dwait_take) begin
                  memwb_en    = 1'b1;
                  memwb_flush = 1'b1;
               end else if (flush_take) begin
                  // redirect fetch regardless of ihit; squash IF/ID and ID/EX
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (bus.lw_nop) begin
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  idex_flush = 1'b1;
               end else if (!bus.ihit) begin
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  ifid_flush = 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
                  memwb_en = 1'b1;
               end
            end
            HALTED:  pc_en = 1'b0;
            default: pc_en = 1'b0;
         endcase
      end
   end

   // Next values for watchdog, sticky flags and saturating counters.
   always_comb begin
      wait_inc    = (wait_cnt_q == 8'hFF) ? 8'hFF : (wait_cnt_q + 8'd1);
      wait_cnt_d  = 8'd0;
      timeout_d   = timeout_q;
      halt_d      = halt_q | halt_take;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (dwait_take) begin
         wait_cnt_d = wait_inc;
         if ({24'd0, wait_inc} >= WAIT_LIMIT) begin
            timeout_d = 1'b1;
         end else begin
            timeout_d = timeout_q;
         end
      end else begin
         wait_cnt_d = 8'd0;
      end
      if (active && !pc_en && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (flush_take && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Status and counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_cnt_q  <= 8'd0;
         halt_q      <= 1'b0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         halt_q      <= halt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.idex_en     = idex_en;
   assign bus.exmem_en    = exmem_en;
   assign bus.memwb_en    = memwb_en;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_flush  = idex_flush;
   assign bus.exmem_flush = exmem_flush;
   assign bus.memwb_flush = memwb_flush;
   assign bus.halt        = halt_q;
   assign bus.mem_timeout = timeout_q;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Two instances share one stimulus:
// u_dut (defaults) and u_small (CNT_W=4, DWAIT_MAX=3) for the watchdog
// threshold and counter saturation.
// Enable/flush vector order: {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,exmem_f,memwb_f}
module tb_pipeline_ctrl;
   logic CLK = 1'b0;
   logic nRST;
   int   n_checks = 0;
   int   n_errors = 0;

   pipeline_ctrl_if #(.CNT_W(32)) bus_b ();
   pipeline_ctrl_if #(.CNT_W(4))  bus_s ();

   pipeline_ctrl #(.CNT_W(32), .DWAIT_MAX(255)) u_dut   (.CLK(CLK), .nRST(nRST), .bus(bus_b));
   pipeline_ctrl #(.CNT_W(4),  .DWAIT_MAX(3))   u_small (.CLK(CLK), .nRST(nRST), .bus(bus_s));

   assign bus_s.lw_nop     = bus_b.lw_nop;
   assign bus_s.jmp_flush  = bus_b.jmp_flush;
   assign bus_s.brch_flush = bus_b.brch_flush;
   assign bus_s.ihit       = bus_b.ihit;
   assign bus_s.exmem_dren = bus_b.exmem_dren;
   assign bus_s.exmem_dwen = bus_b.exmem_dwen;
   assign bus_s.dhit       = bus_b.dhit;
   assign bus_s.exmem_halt = bus_b.exmem_halt;

   logic [8:0] en_b, en_s;
   assign en_b = {bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en, bus_b.memwb_en,
                  bus_b.ifid_flush, bus_b.idex_flush, bus_b.exmem_flush, bus_b.memwb_flush};
   assign en_s = {bus_s.pc_en, bus_s.ifid_en, bus_s.idex_en, bus_s.exmem_en, bus_s.memwb_en,
                  bus_s.ifid_flush, bus_s.idex_flush, bus_s.exmem_flush, bus_s.memwb_flush};

   localparam logic [8:0] V_NORM  = 9'b11111_0000;
   localparam logic [8:0] V_LW    = 9'b00111_0100;
   localparam logic [8:0] V_FLUSH = 9'b11111_1100;
   localparam logic [8:0] V_IMISS = 9'b01111_1000;
   localparam logic [8:0] V_DWAIT = 9'b00001_0001;
   localparam logic [8:0] V_HALT  = 9'b00001_0000;
   localparam logic [8:0] V_ZERO  = 9'b00000_0000;

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic set_idle();
      bus_b.lw_nop     = 1'b0;
      bus_b.jmp_flush  = 1'b0;
      bus_b.brch_flush = 1'b0;
      bus_b.ihit       = 1'b1;
      bus_b.exmem_dren = 1'b0;
      bus_b.exmem_dwen = 1'b0;
      bus_b.dhit       = 1'b0;
      bus_b.exmem_halt = 1'b0;
   endtask

   // advance one clock and land 1 time unit after the rising edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      step();
      nRST = 1'b0;
      set_idle();
      @(negedge CLK);
      nRST = 1'b1;
      step();
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      set_idle();
      bus_b.lw_nop = 1'b1;
      bus_b.ihit   = 1'b0;
      #3;
      n_checks++; if (en_b !== V_ZERO) begin n_errors++; $display("FAIL reset_en got=%b exp=%b", en_b, V_ZERO); end
      n_checks++; if ({bus_b.halt, bus_b.mem_timeout} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got=%b exp=00", {bus_b.halt, bus_b.mem_timeout}); end
      n_checks++; if ((bus_b.stall_cnt !== 32'd0) || (bus_b.flush_cnt !== 32'd0)) begin n_errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus_b.stall_cnt, bus_b.flush_cnt); end
      set_idle();
      @(negedge CLK);
      nRST = 1'b1;
      step();
   endtask

   task automatic test_normal();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (en_b !== V_NORM) begin n_errors++; $display("FAIL normal_en cyc=%0d got=%b exp=%b", i, en_b, V_NORM); end
         step();
      end
      n_checks++; if ((bus_b.stall_cnt !== 32'd0) || (bus_b.flush_cnt !== 32'd0)) begin n_errors++; $display("FAIL normal_cnt got=%0d/%0d exp=0/0", bus_b.stall_cnt, bus_b.flush_cnt); end
   endtask

   task automatic test_lw_nop();
      do_reset();
      bus_b.lw_nop = 1'b1;
      #1;
      n_checks++; if (en_b !== V_LW) begin n_errors++; $display("FAIL lw_en got=%b exp=%b", en_b, V_LW); end
      step();
      bus_b.lw_nop = 1'b0;
      #1;
      n_checks++; if (en_b !== V_NORM) begin n_errors++; $display("FAIL lw_after_en got=%b exp=%b", en_b, V_NORM); end
      n_checks++; if (bus_b.stall_cnt !== 32'd1) begin n_errors++; $display("FAIL lw_stall got=%0d exp=1", bus_b.stall_cnt); end
   endtask

   task automatic test_flush_priority();
      do_reset();
      bus_b.brch_flush = 1'b1;
      bus_b.lw_nop     = 1'b1;
      bus_b.ihit       = 1'b0;
      #1;
      n_checks++; if (en_b !== V_FLUSH) begin n_errors++; $display("FAIL brch_en got=%b exp=%b", en_b, V_FLUSH); end
      step();
      set_idle();
      #1;
      n_checks++; if ((bus_b.flush_cnt !== 32'd1) || (bus_b.stall_cnt !== 32'd0)) begin n_errors++; $display("FAIL brch_cnt got=%0d/%0d exp=1/0", bus_b.flush_cnt, bus_b.stall_cnt); end
      bus_b.jmp_flush = 1'b1;
      #1;
      n_checks++; if (en_b !== V_FLUSH) begin n_errors++; $display("FAIL jmp_en got=%b exp=%b", en_b, V_FLUSH); end
      step();
      set_idle();
      n_checks++; if (bus_b.flush_cnt !== 32'd2) begin n_errors++; $display("FAIL jmp_cnt got=%0d exp=2", bus_b.flush_cnt); end
   endtask

   task automatic test_ihit_miss();
      do_reset();
      bus_b.ihit = 1'b0;
      #1;
      n_checks++; if (en_b !== V_IMISS) begin n_errors++; $display("FAIL imiss_en got=%b exp=%b", en_b, V_IMISS); end
      step();
      set_idle();
      n_checks++; if (bus_b.stall_cnt !== 32'd1) begin n_errors++; $display("FAIL imiss_stall got=%0d exp=1", bus_b.stall_cnt); end
   endtask

   task automatic test_dwait();
      do_reset();
      bus_b.exmem_dren = 1'b1;
      bus_b.lw_nop     = 1'b1;
      bus_b.jmp_flush  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (en_b !== V_DWAIT) begin n_errors++; $display("FAIL dwait_en cyc=%0d got=%b exp=%b", i, en_b, V_DWAIT); end
         step();
      end
      bus_b.lw_nop    = 1'b0;
      bus_b.jmp_flush = 1'b0;
      bus_b.dhit      = 1'b1;
      #1;
      n_checks++; if (en_b !== V_NORM) begin n_errors++; $display("FAIL dwait_exit_en got=%b exp=%b", en_b, V_NORM); end
      step();
      set_idle();
      #1;
      n_checks++; if (en_b !== V_NORM) begin n_errors++; $display("FAIL dwait_run_en got=%b exp=%b", en_b, V_NORM); end
      n_checks++; if (bus_b.stall_cnt !== 32'd4) begin n_errors++; $display("FAIL dwait_stall got=%0d exp=4", bus_b.stall_cnt); end
      n_checks++; if (bus_b.flush_cnt !== 32'd0) begin n_errors++; $display("FAIL dwait_flush got=%0d exp=0", bus_b.flush_cnt); end
      n_checks++; if (bus_b.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL dwait_timeout got=%b exp=0", bus_b.mem_timeout); end
   endtask

   task automatic test_timeout();
      do_reset();
      bus_b.exmem_dwen = 1'b1;
      step();
      step();
      n_checks++; if (bus_s.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_early got=%b exp=0", bus_s.mem_timeout); end
      step();
      n_checks++; if (bus_s.mem_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_set got=%b exp=1", bus_s.mem_timeout); end
      #1;
      n_checks++; if (en_s !== V_DWAIT) begin n_errors++; $display("FAIL timeout_en got=%b exp=%b", en_s, V_DWAIT); end
      step();
      step();
      bus_b.dhit = 1'b1;
      step();
      set_idle();
      step();
      n_checks++; if ({bus_s.mem_timeout, bus_b.mem_timeout} !== 2'b10) begin n_errors++; $display("FAIL timeout_sticky got=%b exp=10", {bus_s.mem_timeout, bus_b.mem_timeout}); end
      n_checks++; if (bus_s.stall_cnt !== 4'd5) begin n_errors++; $display("FAIL timeout_stall got=%0d exp=5", bus_s.stall_cnt); end
      do_reset();
      n_checks++; if (bus_s.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clear got=%b exp=0", bus_s.mem_timeout); end
   endtask

   task automatic test_saturate();
      do_reset();
      bus_b.ihit = 1'b0;
      repeat (20) step();
      set_idle();
      n_checks++; if (bus_b.stall_cnt !== 32'd20) begin n_errors++; $display("FAIL sat_big got=%0d exp=20", bus_b.stall_cnt); end
      n_checks++; if (bus_s.stall_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_small got=%0d exp=15", bus_s.stall_cnt); end
   endtask

   task automatic test_halt();
      do_reset();
      bus_b.exmem_halt = 1'b1;
      #1;
      n_checks++; if (en_b !== V_HALT) begin n_errors++; $display("FAIL halt_en got=%b exp=%b", en_b, V_HALT); end
      step();
      n_checks++; if (bus_b.halt !== 1'b1) begin n_errors++; $display("FAIL halt_flag got=%b exp=1", bus_b.halt); end
      bus_b.exmem_halt = 1'b0;
      bus_b.lw_nop     = 1'b1;
      bus_b.brch_flush = 1'b1;
      bus_b.jmp_flush  = 1'b1;
      bus_b.ihit       = 1'b0;
      #1;
      n_checks++; if (en_b !== V_ZERO) begin n_errors++; $display("FAIL halted_en got=%b exp=%b", en_b, V_ZERO); end
      repeat (3) step();
      n_checks++; if ({bus_b.halt, bus_b.stall_cnt, bus_b.flush_cnt} !== {1'b1, 32'd1, 32'd0}) begin
         n_errors++; $display("FAIL halted_frozen got=%b/%0d/%0d exp=1/1/0", bus_b.halt, bus_b.stall_cnt, bus_b.flush_cnt);
      end
      nRST = 1'b0;
      #1;
      n_checks++; if ((bus_b.halt !== 1'b0) || (bus_b.stall_cnt !== 32'd0)) begin n_errors++; $display("FAIL halt_async_rst got=%b/%0d exp=0/0", bus_b.halt, bus_b.stall_cnt); end
      set_idle();
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      n_checks++; if (en_b !== V_NORM) begin n_errors++; $display("FAIL halt_rst_run got=%b exp=%b", en_b, V_NORM); end
      // HALT behind an outstanding load waits for dhit
      step();
      bus_b.exmem_halt = 1'b1;
      bus_b.exmem_dren = 1'b1;
      #1;
      n_checks++; if (en_b !== V_DWAIT) begin n_errors++; $display("FAIL halt_dwait_en got=%b exp=%b", en_b, V_DWAIT); end
      step();
      n_checks++; if (bus_b.halt !== 1'b0) begin n_errors++; $display("FAIL halt_dwait_flag got=%b exp=0", bus_b.halt); end
      bus_b.dhit = 1'b1;
      #1;
      n_checks++; if (en_b !== V_HALT) begin n_errors++; $display("FAIL halt_dhit_en got=%b exp=%b", en_b, V_HALT); end
      step();
      set_idle();
      n_checks++; if ({bus_b.halt, bus_b.stall_cnt} !== {1'b1, 32'd2}) begin n_errors++; $display("FAIL halt_dhit_flag got=%b/%0d exp=1/2", bus_b.halt, bus_b.stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_lw_nop();
      test_flush_priority();
      test_ihit_miss();
      test_dwait();
      test_timeout();
      test_saturate();
      test_halt();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Pipeline sequencer for the 5-stage MIPS core. It consumes the hazard unit's requests (lw_nop, jmp_flush, brch_flush), the cache handshakes (ihit, dhit), and the MEM-stage halt. It drives per-stage latch enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
It also tracks data-memory wait episodes with a watchdog, latches halt, and keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters
DWAIT_MAX, 255, number of consecutive DWAIT cycles after which mem_timeout is set (8-bit wait counter)

Ports:
CLK  input  1  core clock, rising edge
nRST  input  1  asynchronous active-low reset
lw_nop  input  1  load-use / SC-use stall request from hazard unit
jmp_flush  input  1  J/JAL/JR resolved in EX; flush younger stages
brch_flush  input  1  taken BEQ/BNE resolved in EX; flush younger stages
ihit  input  1  instruction fetch complete this cycle
exmem_dren  input  1  EX/MEM holds a load (LW/LL)
exmem_dwen  input  1  EX/MEM holds a store (SW/SC)
dhit  input  1  data access complete this cycle
exmem_halt  input  1  HALT opcode in EX/MEM
pc_en  output  1  PC register load enable
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load a bubble (zeroed latch) when the matching enable is 1
halt  output  1  sticky core-halted flag
mem_timeout  output  1  sticky watchdog error flag
stall_cnt  output  CNT_W  cycles in which pc_en=0 while not halted
flush_cnt  output  CNT_W  number of control flush events

Behaviour:
- FSM states: RUN, DWAIT, HALTED. Reset sets state=RUN, halt=0, mem_timeout=0, both counters=0, wait counter=0.
- While nRST=0, every enable and flush output is 0.
- dreq = exmem_dren | exmem_dwen.
- Priority order, evaluated every cycle in RUN/DWAIT:
  1. halt
  2. data wait
  3. control flush
  4. lw_nop
  5. ihit miss
  6. normal
- halt: exmem_halt=1 while dreq=0 or dhit=1:
  - memwb_en=1 this cycle; all other enables 0.
  - Next state HALTED, halt<=1.
  - HALTED: all enables and flushes 0; exit only by reset.
- data wait: dreq=1 & dhit=0:
  - pc_en, ifid_en, idex_en, exmem_en = 0.
  - memwb_en=1 with memwb_flush=1 (bubble into WB).
  - State moves to DWAIT; the wait counter increments, saturating at 255.
  - When the wait counter reaches DWAIT_MAX, mem_timeout<=1. It is sticky and does not stall the pipe.
- DWAIT exit: the cycle dhit=1 arrives is a normal advance cycle, evaluated at lower priorities. State returns to RUN and the wait counter clears.
- control flush: jmp_flush | brch_flush:
  - All enables 1, pc_en=1 even if ihit=0.
  - ifid_flush=1, idex_flush=1.
  - flush_cnt += 1 (one per cycle asserted).
  - lw_nop is ignored that cycle.
- lw_nop:
  - pc_en=0, ifid_en=0.
  - idex_en=1 with idex_flush=1; exmem_en and memwb_en = 1.
- ihit miss: ihit=0:
  - pc_en=0.
  - ifid_en=1 with ifid_flush=1; downstream enables 1.
- normal: all enables 1, all flushes 0.
- stall_cnt += 1 in every cycle with pc_en=0 while state is not HALTED and nRST=1. This includes the halt-entry cycle.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Enable and flush outputs are combinational from state and inputs. halt, mem_timeout and the counters are registered.
- Asynchronous reset mid-DWAIT or in HALTED returns to RUN immediately. Counters and flags clear asynchronously.

Test Plan:
- Reset then ihit=1, no requests for 5 cycles -> all enables 1, flushes 0, stall_cnt=0, flush_cnt=0.
- lw_nop=1 for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; next cycle normal; stall_cnt=1.
- brch_flush=1 with lw_nop=1 and ihit=0 in the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt=1, stall_cnt=0.
- exmem_dren=1, dhit=0 for 4 cycles, then dhit=1 -> 4 frozen cycles with memwb_flush=1; state DWAIT then RUN; stall_cnt=4; mem_timeout=0.
- DWAIT_MAX=3, dwen=1, dhit=0 for 5 cycles -> mem_timeout=1 after the 3rd wait cycle; stays 1 after dhit=1; clears only on nRST=0.
- exmem_halt=1, dreq=0 -> memwb_en=1 only, halt=1 next edge; then lw_nop and flushes are ignored (all outputs 0, counters frozen). nRST pulse -> halt=0, RUN.
